// File: rtl/sync_stream_fifo.sv
// Single-clock ready/valid FIFO with first-word-fall-through read, occupancy count and flags.
// Define SYNC_STREAM_FIFO_STATS_EN to add the io_highWater / io_overflowCnt statistics outputs.
module sync_stream_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    output logic                        io_enq_ready,
    input  logic                        io_enq_valid,
    input  logic [DATA_WIDTH-1:0]       io_enq_bits,
    input  logic                        io_deq_ready,
    output logic                        io_deq_valid,
    output logic [DATA_WIDTH-1:0]       io_deq_bits,
    input  logic                        io_flush,
    output logic [$clog2(DEPTH):0]      io_count,
    output logic                        io_almostFull,
`ifdef SYNC_STREAM_FIFO_STATS_EN
    output logic [$clog2(DEPTH):0]      io_highWater,
    output logic [15:0]                 io_overflowCnt,
`endif
    output logic                        io_almostEmpty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);
    localparam logic [AW:0] AF_L = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_L = (AW+1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wptr, rptr, count;
    logic        full, empty, enq_fire, deq_fire;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign io_enq_ready = ~full & ~reset;
    assign io_deq_valid = ~empty;
    assign io_deq_bits  = mem[rptr[AW-1:0]];
    assign enq_fire = io_enq_valid & io_enq_ready;
    assign deq_fire = io_deq_valid & io_deq_ready;

    assign io_count       = count;
    assign io_almostFull  = (count >= AF_L);
    assign io_almostEmpty = (count <= AE_L);

    always_ff @(posedge clock) begin
        if (enq_fire && !io_flush)
            mem[wptr[AW-1:0]] <= io_enq_bits;
    end

    always_ff @(posedge clock) begin
        if (reset || io_flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (enq_fire) wptr <= wptr + ONE;
            if (deq_fire) rptr <= rptr + ONE;
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

`ifdef SYNC_STREAM_FIFO_STATS_EN
    // Statistics survive flush; only reset clears them.
    always_ff @(posedge clock) begin
        if (reset) begin
            io_highWater   <= '0;
            io_overflowCnt <= '0;
        end else begin
            if (count > io_highWater) io_highWater <= count;
            if (io_enq_valid && full && (io_overflowCnt != 16'hFFFF))
                io_overflowCnt <= io_overflowCnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sync_stream_fifo.sv
// Self-checking bench for sync_stream_fifo: directed plan plus random traffic against a queue model.
module tb_sync_stream_fifo;
    localparam int DW = 64;
    localparam int DEPTH = 4;
    localparam int AW = 2;
    localparam int AF = DEPTH - 1;
    localparam int AE = 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enq_ready, enq_valid = 1'b0, deq_ready = 1'b0, deq_valid, flush = 1'b0;
    logic [DW-1:0] enq_bits = '0, deq_bits;
    logic [AW:0]   count;
    logic          almost_full, almost_empty;
`ifdef SYNC_STREAM_FIFO_STATS_EN
    logic [AW:0]   high_water;
    logic [15:0]   overflow_cnt;
    int            hw_m = 0, ovf_m = 0;
`endif

    int checks = 0, failures = 0;
    bit known = 1'b0;
    logic [DW-1:0] q[$];

    sync_stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .io_enq_ready(enq_ready), .io_enq_valid(enq_valid), .io_enq_bits(enq_bits),
        .io_deq_ready(deq_ready), .io_deq_valid(deq_valid), .io_deq_bits(deq_bits),
        .io_flush(flush), .io_count(count), .io_almostFull(almost_full),
`ifdef SYNC_STREAM_FIFO_STATS_EN
        .io_highWater(high_water), .io_overflowCnt(overflow_cnt),
`endif
        .io_almostEmpty(almost_empty)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then advance the model.
    task automatic cyc(input logic ev, input logic [DW-1:0] eb, input logic dr,
                       input logic fl, input logic rs);
        int n;
        bit ef, df;
        @(negedge clock);
        enq_valid = ev; enq_bits = eb; deq_ready = dr; flush = fl; reset = rs;
        #1;
        n = q.size();
        if (rs) chk("enq_ready_in_reset", enq_ready, 0);
        if (known) begin
            if (!rs) chk("enq_ready", enq_ready, (n < DEPTH));
            chk("count", count, n);
            chk("deq_valid", deq_valid, (n > 0));
            chk("almost_full", almost_full, (n >= AF));
            chk("almost_empty", almost_empty, (n <= AE));
            if (n > 0) chk("deq_bits", deq_bits, q[0]);
`ifdef SYNC_STREAM_FIFO_STATS_EN
            chk("high_water", high_water, hw_m);
            chk("overflow_cnt", overflow_cnt, ovf_m);
`endif
        end
        ef = ev && !rs && (n < DEPTH);
        df = dr && (n > 0);
        @(posedge clock);
`ifdef SYNC_STREAM_FIFO_STATS_EN
        if (rs) begin
            hw_m = 0; ovf_m = 0;
        end else begin
            if (n > hw_m) hw_m = n;
            if (ev && n == DEPTH && ovf_m < 65535) ovf_m++;
        end
`endif
        if (rs || fl) q.delete();
        else begin
            if (df) void'(q.pop_front());
            if (ef) q.push_back(eb);
        end
        if (rs) known = 1'b1;
    endtask

    initial begin
        cyc(0, 0, 0, 0, 1);
        // Fill with consumer stalled, then hold a fifth word that must not enter.
        for (int i = 1; i <= 4; i++) cyc(1, 64'(8'h11 * i), 0, 0, 0);
        cyc(1, 64'h55, 0, 0, 0);
        cyc(1, 64'h55, 0, 0, 0);
        // Drain in order, then poke an empty FIFO.
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        // Streaming with both sides always ready; pointers wrap several times.
        for (int i = 0; i < 20; i++) cyc(1, 64'(32'h100 + i), 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        // Flush wins over a same-cycle enqueue.
        for (int i = 0; i < 3; i++) cyc(1, 64'(8'hC0 + i), 0, 0, 0);
        cyc(1, 64'hAA, 0, 1, 0);
        cyc(1, 64'hBB, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        // Reset mid-operation.
        cyc(1, 64'hD1, 0, 0, 0);
        cyc(1, 64'hD2, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        // Overflow attempts while full, drain, flush: statistics must persist.
        for (int i = 0; i < 4; i++) cyc(1, 64'(8'hE0 + i), 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 64'hEE, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
`ifdef SYNC_STREAM_FIFO_STATS_EN
        chk("high_water_after_flush", high_water, 4);
        chk("overflow_after_flush", overflow_cnt, 5);
`endif
        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 59) == 0));
        cyc(0, 0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sync_stream_fifo.md
Name: sync_stream_fifo

Overview:
- Parametrised single-clock FIFO with ready/valid handshakes on both enqueue and dequeue ports.
- Generalises the fixed 64-bit, depth-4, auto-draining FIFO wrapper: configurable width and depth, and the read side is back-pressured by the consumer.
- Adds occupancy count, almost-full/almost-empty flags and a synchronous flush.
- Used between cave sprite/tile fetch units and DDR burst interfaces wherever both sides share one clock.

Parameters:
- DATA_WIDTH, 64, payload width in bits (>=1).
- DEPTH, 4, entries; power of two, >=2.
- AF_LEVEL, DEPTH-1, io_almostFull asserts when count >= AF_LEVEL.
- AE_LEVEL, 1, io_almostEmpty asserts when count <= AE_LEVEL.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- io_enq_ready  out  1  FIFO can accept a word this cycle.
- io_enq_valid  in  1  producer offers io_enq_bits.
- io_enq_bits  in  DATA_WIDTH  write data.
- io_deq_ready  in  1  consumer takes the head word this cycle.
- io_deq_valid  out  1  head word present on io_deq_bits.
- io_deq_bits  out  DATA_WIDTH  head word (first-word-fall-through).
- io_flush  in  1  discard all contents.
- io_count  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- io_almostFull  out  1  count >= AF_LEVEL.
- io_almostEmpty  out  1  count <= AE_LEVEL.

Behaviour:
- Storage: register array of DEPTH x DATA_WIDTH.
- Pointers: write and read pointers are log2(DEPTH)+1 bits.
  - Wrap is natural modulo 2*DEPTH.
  - Full when the pointers differ only in the MSB; empty when they are equal.
- Reset: pointers and count go to 0.
  - io_deq_valid=0, io_count=0, io_almostFull=0, io_almostEmpty=1.
  - io_enq_ready is forced 0 while reset is high and is 1 in the first cycle after reset.
- Enqueue fires when io_enq_valid & io_enq_ready.
  - The word is written at wptr and wptr increments at the clock edge.
- io_enq_ready = ~full. It does not depend on io_deq_ready; there is no combinational path from deq to enq.
- Dequeue fires when io_deq_valid & io_deq_ready; rptr increments at the clock edge.
- io_deq_valid = ~empty.
- io_deq_bits = mem[rptr] combinationally. Its value is undefined when io_deq_valid=0.
- Latency: a word enqueued into an empty FIFO at edge N is visible with io_deq_valid=1 in the cycle after edge N. There is no same-cycle pass-through.
- Simultaneous enq and deq, not full and not empty: both fire and the count is unchanged.
- Full: io_enq_ready=0 even if a dequeue fires in the same cycle. A write is accepted again in the cycle after the dequeue.
- Empty: io_deq_valid=0. Any io_deq_ready is ignored and no pointer moves.
- Count: registered. Next value = count + enq_fire - deq_fire, never outside 0..DEPTH.
- Flags: io_almostFull and io_almostEmpty are combinational from the count register.
- Flush: sampled at the clock edge and highest priority.
  - Both pointers and the count go to 0.
  - Any enq_fire or deq_fire in the flush cycle is discarded: the word is not stored and the read is not counted.
  - io_enq_ready stays as computed in the flush cycle. A producer seeing a handshake there must treat the word as dropped; this is documented upstream.
- Reset mid-operation has the same effect as flush, plus io_enq_ready=0 for the reset cycle(s).
- Data is never corrupted by pointer wrap; order is strictly FIFO.

Optional Feature:
- Macro: SYNC_STREAM_FIFO_STATS_EN.
- Defined: adds output io_highWater [log2(DEPTH)+1].
  - It is the maximum io_count seen since reset.
  - Updated one cycle after io_count changes; cleared by reset only, not by flush.
  - Also adds output io_overflowCnt [16]: increments every cycle with io_enq_valid=1 and full=1, saturating at 0xFFFF, cleared by reset.
- Undefined: neither port exists and there is no extra logic.

Test Plan:
- DEPTH=4, WIDTH=64, deq_ready=0: enqueue 0x11,0x22,0x33,0x44 on consecutive cycles -> io_count 1,2,3,4; io_enq_ready=0 after the 4th; io_almostFull=1 from count 3; a 5th word 0x55 held on enq_valid is not accepted.
- From full, deq_ready=1 for 4 cycles -> io_deq_bits 0x11,0x22,0x33,0x44 in order; io_deq_valid falls after the 4th; io_almostEmpty=1 at count<=1; count returns to 0.
- Continuous enq_valid=1 and deq_ready=1 with an incrementing pattern for 20 cycles -> count settles at 1; output sequence is identical to the input with one-cycle latency; pointers wrap with no loss or duplication.
- Fill to 3, then pulse io_flush with enq_valid=1 (0xAA) in the same cycle -> next cycle count=0, io_deq_valid=0; 0xAA is never dequeued; a subsequent enqueue of 0xBB is dequeued first.
- Assert reset for 1 cycle while at count=2 -> io_enq_ready=0 during reset; next cycle count=0, io_enq_ready=1, io_deq_valid=0.
- With SYNC_STREAM_FIFO_STATS_EN: fill to 4, hold enq_valid=1 for 5 extra cycles, drain, flush -> io_highWater=4 and io_overflowCnt=5, both retained after the flush.
